// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with write-back bypass, load-use
// hazard bubbling, stall/flush handling and a saturating bubble counter.
`default_nettype none

module id_ex_operand_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_reg,
    input  logic [31:0]       wb_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              id_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q,    valid_d;
    logic [31:0]       a_q,        a_d;
    logic [31:0]       b_q,        b_d;
    logic [31:0]       imm_q,      imm_d;
    logic [4:0]        rs_q,       rs_d;
    logic [4:0]        rt_q,       rt_d;
    logic [4:0]        dst_q,      dst_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q,  memread_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic        wb_hit;
    logic [31:0] byp1;
    logic [31:0] byp2;
    logic        hz;

    // Register-file writes land at the edge, so a same-cycle write-back must be
    // forwarded into the combinational read data. $0 is hardwired and never forwarded.
    assign wb_hit = wb_we && (wb_reg != 5'd0);
    assign byp1   = (wb_hit && (wb_reg == id_rs)) ? wb_data : rf_rdata1;
    assign byp2   = (wb_hit && (wb_reg == id_rt)) ? wb_data : rf_rdata2;

    assign hz = valid_q && memread_q && (dst_q != 5'd0) && id_valid &&
                ((dst_q == id_rs) || (dst_q == id_rt));

    assign id_stall = !flush && (ex_stall || hz);

    always_comb begin
        valid_d    = valid_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        dst_d      = dst_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;

        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (ex_stall) begin
            // A held entry would otherwise miss a write-back that retires while it waits.
            if (wb_hit && (wb_reg == rs_q)) a_d = wb_data;
            if (wb_hit && (wb_reg == rt_q)) b_d = wb_data;
        end else if (hz) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end else begin
            valid_d    = id_valid;
            a_d        = byp1;
            b_d        = byp2;
            imm_d      = id_imm;
            rs_d       = id_rs;
            rt_d       = id_rt;
            dst_d      = id_dst;
            regwrite_d = id_valid && id_regwrite;
            memread_d  = id_valid && id_memread;
            ctrl_d     = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            dst_q      <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dst_q      <= dst_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_a        = a_q;
    assign ex_b        = b_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dst      = dst_q;
    assign ex_regwrite = regwrite_q;
    assign ex_memread  = memread_q;
    assign ex_ctrl     = ctrl_q;
    assign bubble_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage (CNT_W=4 build).
`default_nettype none

module tb_id_ex_operand_stage;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_dst;
    logic [31:0]       rf_rdata1, rf_rdata2, id_imm;
    logic              id_regwrite, id_memread;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_we;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              ex_stall, flush;
    logic              ex_valid;
    logic [31:0]       ex_a, ex_b, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_dst;
    logic              ex_regwrite, ex_memread;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              id_stall;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .id_imm(id_imm), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .ex_stall(ex_stall),
        .flush(flush), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_ctrl(ex_ctrl), .id_stall(id_stall),
        .bubble_cnt(bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] dst,
                          input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; rf_rdata1 = d1; rf_rdata2 = d2;
        id_dst = dst; id_regwrite = rw; id_memread = mr;
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        id_imm = 32'h0; id_ctrl = '0;
        wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;
        ex_stall = 1'b0; flush = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(ex_valid), 32'h0);
        check("rst_a", ex_a, 32'h0);
        check("rst_cnt", 32'(bubble_cnt), 32'h0);
        rst_n = 1'b1;

        // Basic load, no bypass
        set_id(1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 5'd6, 1'b1, 1'b0);
        id_imm = 32'h100; id_ctrl = 8'hA5;
        #1 check("basic_stall", 32'(id_stall), 32'h0);
        tick();
        check("basic_valid", 32'(ex_valid), 32'h1);
        check("basic_a", ex_a, 32'h11);
        check("basic_b", ex_b, 32'h22);
        check("basic_imm", ex_imm, 32'h100);
        check("basic_ctrl", 32'(ex_ctrl), 32'hA5);
        check("basic_rw", 32'(ex_regwrite), 32'h1);

        // WB bypass on rs, then on rt, then $0 never bypassed
        wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD;
        tick();
        check("byp1_a", ex_a, 32'hDEAD);
        check("byp1_b", ex_b, 32'h22);
        wb_reg = 5'd4; wb_data = 32'hCAFE;
        tick();
        check("byp2_a", ex_a, 32'h11);
        check("byp2_b", ex_b, 32'hCAFE);
        wb_reg = 5'd0; wb_data = 32'hDEAD; id_rs = 5'd0; rf_rdata1 = 32'h0;
        tick();
        check("r0_a", ex_a, 32'h0);
        wb_we = 1'b0;

        // Load-use hazard: one bubble, then the dependent loads
        set_id(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 5'd5, 1'b1, 1'b1);
        tick();
        check("lw_memread", 32'(ex_memread), 32'h1);
        check("lw_dst", 32'(ex_dst), 32'h5);
        set_id(1'b1, 5'd5, 5'd2, 32'h0, 32'h2, 5'd8, 1'b1, 1'b0);
        #1 check("hz_stall", 32'(id_stall), 32'h1);
        tick();
        exp_cnt = 1;
        check("bub_valid", 32'(ex_valid), 32'h0);
        check("bub_rw", 32'(ex_regwrite), 32'h0);
        check("bub_cnt", 32'(bubble_cnt), 32'(exp_cnt));
        check("bub_nostall", 32'(id_stall), 32'h0);
        rf_rdata1 = 32'h55;
        tick();
        check("dep_valid", 32'(ex_valid), 32'h1);
        check("dep_rs", 32'(ex_rs), 32'h5);
        check("dep_a", ex_a, 32'h55);

        // Stall with held-entry refresh on ex_rs=7
        set_id(1'b1, 5'd7, 5'd9, 32'h70, 32'h90, 5'd10, 1'b1, 1'b0);
        id_imm = 32'h77;
        tick();
        check("pre_a", ex_a, 32'h70);
        ex_stall = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 32'h1234, 32'h5678, 5'd11, 1'b0, 1'b0);
        id_imm = 32'h999;
        #1 check("stl0_stall", 32'(id_stall), 32'h1);
        tick();
        check("stl1_a", ex_a, 32'h70);
        check("stl1_imm", ex_imm, 32'h77);
        check("stl1_stall", 32'(id_stall), 32'h1);
        wb_we = 1'b1; wb_reg = 5'd7; wb_data = 32'hBEEF;
        tick();
        wb_we = 1'b0;
        check("stl2_a", ex_a, 32'hBEEF);
        check("stl2_b", ex_b, 32'h90);
        check("stl2_rs", 32'(ex_rs), 32'h7);
        check("stl2_dst", 32'(ex_dst), 32'hA);
        check("stl2_stall", 32'(id_stall), 32'h1);
        tick();
        check("stl3_a", ex_a, 32'hBEEF);
        check("stl3_imm", ex_imm, 32'h77);
        ex_stall = 1'b0;

        // Flush concurrent with a hazard
        set_id(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 32'h0, 32'h2, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1 check("fl_stall", 32'(id_stall), 32'h0);
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(ex_valid), 32'h0);
        check("fl_rw", 32'(ex_regwrite), 32'h0);
        check("fl_cnt", 32'(bubble_cnt), 32'(exp_cnt));

        // Saturation: 2^CNT_W+2 hazards
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            set_id(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 5'd5, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd2, 5'd5, 32'h0, 32'h2, 5'd8, 1'b1, 1'b0);
            tick();
            if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            check("sat_cnt", 32'(bubble_cnt), 32'(exp_cnt));
        end
        check("sat_final", 32'(bubble_cnt), 32'hF);

        // Invalid ID forces control low
        set_id(1'b0, 5'd1, 5'd2, 32'h1, 32'h2, 5'd9, 1'b1, 1'b1);
        tick();
        check("inv_valid", 32'(ex_valid), 32'h0);
        check("inv_rw", 32'(ex_regwrite), 32'h0);
        check("inv_mr", 32'(ex_memread), 32'h0);

        // Asynchronous reset mid-stall
        set_id(1'b1, 5'd3, 5'd4, 32'h33, 32'h44, 5'd6, 1'b1, 1'b0);
        tick();
        check("ar_pre", 32'(ex_valid), 32'h1);
        ex_stall = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(ex_valid), 32'h0);
        check("ar_a", ex_a, 32'h0);
        check("ar_cnt", 32'(bubble_cnt), 32'h0);
        check("ar_rw", 32'(ex_regwrite), 32'h0);
        #1 rst_n = 1'b1;
        ex_stall = 1'b0;
        set_id(1'b1, 5'd3, 5'd4, 32'h66, 32'h77, 5'd6, 1'b1, 1'b0);
        tick();
        check("post_valid", 32'(ex_valid), 32'h1);
        check("post_a", ex_a, 32'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
